// File: rtl/aes_key_expander_iter.sv
// rtl/aes_key_expander_iter.sv - iterative AES-128/192/256 key expansion streaming round keys; AES_KEYEXP_ZEROIZE_EN clears key state after the last transfer
module aes_key_expander_iter #(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [32*NK-1:0] key_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_key,
    output logic [3:0]       out_round,
    output logic             done
);

    localparam int         NR      = NK + 6;
    localparam logic [5:0] NK_W    = 6'(NK);
    localparam logic [5:0] LAST_W  = 6'(4 * NR + 3);
    localparam logic [2:0] POS_MAX = 3'(NK - 1);
    localparam logic [3:0] NR_W    = 4'(NR);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_key_expander_iter: NK must be 4, 6 or 8");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [32*NK-1:0]  key_reg;
    // window holds the last NK words: [31:0] is w[i-1], the top word is w[i-NK]
    logic [32*NK-1:0]  window;
    // the three most recent words of the round key being assembled
    logic [95:0]       collect;
    logic [5:0]        word_idx;
    logic [2:0]        pos;
    logic [7:0]        rcon;

    logic [31:0] w_prev;
    logic [31:0] w_old;
    logic [31:0] key_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] new_word;
    logic        from_key;
    logic        words_left;
    logic        adv;
    logic        gen;
    logic        xfer;
    logic        final_xfer;

    // next schedule word: key words first, then the shared RotWord/SubWord/Rcon datapath
    always_comb begin
        w_prev   = window[31:0];
        w_old    = window[32*NK-1 -: 32];
        key_word = '0;
        for (int n = 0; n < NK; n++) begin
            if (pos == 3'(n)) begin
                key_word = key_reg[32*(NK-1-n) +: 32];
            end
        end
        sub_in   = (pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                    sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
        from_key = word_idx < NK_W;
        if (from_key) begin
            new_word = key_word;
        end else if (pos == 3'd0) begin
            new_word = w_old ^ sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && pos == 3'd4) begin
            new_word = w_old ^ sub_out;
        end else begin
            new_word = w_old ^ w_prev;
        end
    end

    assign words_left = word_idx <= LAST_W;
    assign adv        = !out_valid || out_ready;
    assign gen        = (state == RUN) && adv && words_left;
    assign xfer       = (state == RUN) && out_valid && out_ready;
    assign final_xfer = xfer && (out_round == NR_W);
    assign done       = final_xfer;

    // control FSM, word generation and round-key output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_key   <= '0;
            out_round <= '0;
            key_reg   <= '0;
            window    <= '0;
            collect   <= '0;
            word_idx  <= '0;
            pos       <= '0;
            rcon      <= 8'h01;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg  <= key_in;
                        word_idx <= '0;
                        pos      <= '0;
                        rcon     <= 8'h01;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (final_xfer) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
`ifdef AES_KEYEXP_ZEROIZE_EN
                        key_reg   <= '0;
                        window    <= '0;
                        collect   <= '0;
                        out_key   <= '0;
`endif
                    end else if (gen) begin
                        window   <= {window[32*(NK-1)-1:0], new_word};
                        collect  <= {collect[63:0], new_word};
                        word_idx <= word_idx + 6'd1;
                        pos      <= (pos == POS_MAX) ? 3'd0 : pos + 3'd1;
                        if (!from_key && pos == 3'd0) begin
                            rcon <= xtime(rcon);
                        end
                        if (word_idx[1:0] == 2'd3) begin
                            out_valid <= 1'b1;
                            out_key   <= {collect, new_word};
                            out_round <= word_idx[5:2];
                        end else if (xfer) begin
                            out_valid <= 1'b0;
                        end
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expander_iter.sv
// tb/tb_aes_key_expander_iter.sv - self-checking bench for aes_key_expander_iter at NK=4/6/8
module tb_aes_key_expander_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   start;
    logic [2:0]   out_ready;
    logic [255:0] kin [3];
    wire  [2:0]   busy;
    wire  [2:0]   out_valid;
    wire  [2:0]   done;
    wire  [127:0] out_key [3];
    wire  [3:0]   out_round [3];

    always #5 clk = ~clk;

    aes_key_expander_iter #(.NK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(kin[0][127:0]),
        .busy(busy[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_key(out_key[0]), .out_round(out_round[0]), .done(done[0]));

    aes_key_expander_iter #(.NK(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(kin[1][191:0]),
        .busy(busy[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_key(out_key[1]), .out_round(out_round[1]), .done(done[1]));

    aes_key_expander_iter #(.NK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(kin[2]),
        .busy(busy[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_key(out_key[2]), .out_round(out_round[2]), .done(done[2]));

    logic [7:0]   sb [256];
    logic [127:0] model_rk [3][15];
    logic [127:0] captured [3][15];
    int           exp_ptr [3];
    logic         exp_active [3];
    int           xfer_cnt [3];
    logic         prev_stall [3];
    logic [127:0] prev_key [3];
    logic [3:0]   prev_round [3];
    int           n_pass = 0;
    int           n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int nk_of(input int k);
        return 4 + 2 * k;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int s);
        logic [7:0] r;
        r = b;
        for (int n = 0; n < s; n++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // FIPS-197 key expansion written straight from the word recurrence
    task automatic build_model(input int k, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        nk = nk_of(k);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*(nk-i)-1 -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j <= nk + 6; j++) model_rk[k][j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // one compare process: every transfer against the model, holds during stalls, done placement
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                prev_stall[k] = 1'b0;
            end else begin
                if (prev_stall[k]) begin
                    check("hold_valid", 128'(out_valid[k]), 128'd1);
                    check("hold_key", out_key[k], prev_key[k]);
                    check("hold_round", 128'(out_round[k]), 128'(prev_round[k]));
                end
                if (out_valid[k] && out_ready[k]) begin
                    check("xfer_expected", 128'(exp_active[k]), 128'd1);
                    if (exp_active[k]) begin
                        check("round", 128'(out_round[k]), 128'(exp_ptr[k]));
                        check("key", out_key[k], model_rk[k][exp_ptr[k]]);
                        check("done_on_xfer", 128'(done[k]), 128'(exp_ptr[k] == nk_of(k) + 6));
                        captured[k][exp_ptr[k]] = out_key[k];
                        xfer_cnt[k]++;
                        exp_ptr[k]++;
                        if (exp_ptr[k] > nk_of(k) + 6) exp_active[k] = 1'b0;
                    end
                end else begin
                    check("done_idle", 128'(done[k]), 128'd0);
                end
                prev_stall[k] = out_valid[k] && !out_ready[k];
                prev_key[k]   = out_key[k];
                prev_round[k] = out_round[k];
            end
        end
    end

    task automatic run(input int k, input logic [255:0] key, input bit rand_ready,
                       input bit timing, input bit poke_start, input int abort_round,
                       output bit aborted);
        int nr, first_valid, done_at;
        logic [127:0] exp_k;
        nr = nk_of(k) + 6;
        aborted = 1'b0;
        build_model(k, key);
        @(posedge clk); #1;
        kin[k] = key;
        start[k] = 1'b1;
        out_ready[k] = 1'b1;
        exp_ptr[k] = 0;
        exp_active[k] = 1'b1;
        xfer_cnt[k] = 0;
        for (int j = 0; j < 15; j++) captured[k][j] = '0;
        @(posedge clk); #1;
        start[k] = 1'b0;
        first_valid = -1;
        done_at = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready[k] = ($urandom_range(0, 3) != 0);
            if (poke_start) begin
                if (n == 7) begin
                    kin[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                    start[k] = 1'b1;
                end else begin
                    start[k] = 1'b0;
                end
            end
            @(negedge clk);
            if (n == 1) check("busy_run", 128'(busy[k]), 128'd1);
            if (out_valid[k] && first_valid < 0) first_valid = n;
            if (abort_round >= 0 && out_valid[k] && out_round[k] == 4'(abort_round)) begin
                aborted = 1'b1;
                break;
            end
            if (done[k]) begin
                done_at = n;
                break;
            end
        end
        start[k] = 1'b0;
        if (!aborted) begin
            if (done_at < 0) begin
                n_total++;
                $display("FAIL timeout: no done from instance %0d within 2000 cycles", k);
            end
            if (timing) begin
                check("first_key_edge", 128'(first_valid), 128'd4);
                check("done_edge", 128'(done_at), 128'(4 * (nr + 1)));
            end
            @(posedge clk); #1;
            out_ready[k] = 1'b1;
            @(negedge clk);
            check("busy_after", 128'(busy[k]), 128'd0);
            check("valid_after", 128'(out_valid[k]), 128'd0);
            check("all_keys", 128'(exp_active[k]), 128'd0);
            check("xfer_count", 128'(xfer_cnt[k]), 128'(nr + 1));
`ifdef AES_KEYEXP_ZEROIZE_EN
            exp_k = '0;
`else
            exp_k = model_rk[k][nr];
`endif
            check("key_after_done", out_key[k], exp_k);
        end
    endtask

    initial begin
        bit           ab;
        logic [255:0] rk;
        logic [7:0]   inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rst_n = 1'b0;
        start = 3'b000;
        out_ready = 3'b111;
        for (int k = 0; k < 3; k++) begin
            kin[k] = '0;
            exp_active[k] = 1'b0;
            exp_ptr[k] = 0;
            xfer_cnt[k] = 0;
        end
        check("sbox_00", 128'(sb[8'h00]), 128'h63);
        check("sbox_53", 128'(sb[8'h53]), 128'hed);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", 128'(busy[k]), 128'd0);
            check("rst_valid", 128'(out_valid[k]), 128'd0);
            check("rst_done", 128'(done[k]), 128'd0);
            check("rst_key", out_key[k], 128'd0);
            check("rst_round", 128'(out_round[k]), 128'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1, 1'b0, -1, ab);
        check("model_r1_nk4", model_rk[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("dut_r1_nk4", captured[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("dut_r10_nk4", captured[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 1'b0, 1'b1, 1'b0, -1, ab);
        check("model_r12_nk6", model_rk[1][12], 128'he98ba06f448c773c8ecc720401002202);
        check("dut_r12_nk6", captured[1][12], 128'he98ba06f448c773c8ecc720401002202);
        check("dut_xfers_nk6", 128'(xfer_cnt[1]), 128'd13);

        run(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0, 1'b1, 1'b0, -1, ab);
        check("dut_r0_nk8", captured[2][0], 128'h603deb1015ca71be2b73aef0857d7781);
        check("model_r14_nk8", model_rk[2][14], 128'hfe4890d1e6188d0b046df344706c631e);
        check("dut_r14_nk8", captured[2][14], 128'hfe4890d1e6188d0b046df344706c631e);

        run(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b0, 1'b1, -1, ab);
        check("stall_r1_nk4", captured[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("stall_r10_nk4", captured[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                run(k, rk, 1'b1, 1'b0, (r == 1), -1, ab);
            end
        end

        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(0, rk, 1'b0, 1'b0, 1'b0, 5, ab);
        check("abort_reached", 128'(ab), 128'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_active[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 128'(busy[0]), 128'd0);
        check("mid_rst_valid", 128'(out_valid[0]), 128'd0);
        check("mid_rst_done", 128'(done[0]), 128'd0);
        check("mid_rst_key", out_key[0], 128'd0);
        check("mid_rst_round", 128'(out_round[0]), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(0, rk, 1'b0, 1'b1, 1'b0, -1, ab);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_key_expander_iter.md
# aes_key_expander_iter

Iterative, parametrised AES key expansion engine for AES-128, AES-192 and AES-256. It computes one 32-bit key-schedule word per cycle using a single 4-S-box datapath: RotWord/SubWord/Rcon on `i mod NK == 0`, SubWord only on `i mod NK == 4` when NK=8. It delivers 128-bit round keys in order over a valid/ready stream. It sits between the key register and the iterative round datapath, and replaces the fixed 128-bit g-function/key-schedule pair.

## Interface
- `NK`, default 4: key length in 32-bit words. Legal values are 4, 6 and 8; any other value is an elaboration error. NR = NK+6.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request an expansion. Sampled only in IDLE.
- `key_in` in 32*NK: cipher key. Word w0 = `key_in[32*NK-1 -: 32]`; byte 0 is the MSB of each word.
- `busy` out 1: high from the cycle after `start` is accepted until the return to IDLE.
- `out_valid` out 1: `out_key`/`out_round` hold a round key.
- `out_ready` in 1: consumer accepts; transfer happens when `out_valid && out_ready`.
- `out_key` out 128: round key {w4j, w4j+1, w4j+2, w4j+3}.
- `out_round` out 4: round index j, 0..NR.
- `done` out 1: one-cycle pulse on the transfer of round NR.

## Operation
- Reset: state IDLE, `busy`=0, `out_valid`=0, `done`=0, `out_key`=0, `out_round`=0. The window, word counter i and the collect register are all cleared, and rcon=0x01.
- States are IDLE and RUN.
- IDLE→RUN when `start`=1. That edge captures `key_in` into the NK-word window source, sets i=0 and sets rcon=0x01. `start` in RUN is ignored.
- RUN, advance condition: `adv = !out_valid || out_ready`. On each edge with `adv`, word i is produced and shifted into both the window and the 4-word collect register:
  - i<NK: word i is taken from the captured key.
  - i≥NK, i mod NK==0: w[i-NK] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}. After use, rcon = xtime(rcon), i.e. 0x1B reduction.
  - NK==8, i mod NK==4: w[i-NK] ^ SubWord(w[i-1]).
  - Otherwise: w[i-NK] ^ w[i-1].
- On producing a word with i mod 4==3:
  - next `out_valid`=1, `out_key`=collect contents including the new word, `out_round`=i>>2.
  - If i mod 4 != 3 and a transfer occurs, `out_valid` clears.
- When `adv`=0, nothing advances, and `out_key`/`out_round` are held stable.
- After word 4*NR+3 is produced, no further words are generated. On that key's transfer: `done`=1 for one cycle, state→IDLE, `busy`=0.
- Rcon is 8 bits. The sequence for NK=4 is 01,02,04,08,10,20,40,80,1B,36.
- Reset asserted mid-expansion aborts immediately to the reset values. A partially streamed key is discarded.

## Timing
- `start` accepted at edge E0. Round key 0 is valid after E4.
- With `out_ready` held at 1, round key j is valid after edge E4(j+1), for exactly one cycle.
- The last key is valid after E44 (NK=4), E52 (NK=6) or E60 (NK=8). `done` is asserted in that same cycle.
- Backpressure of k cycles delays all subsequent keys by exactly k cycles.
- A new `start` is accepted no earlier than the cycle after `done`.
- The S-box path is combinational within one cycle. There is no multicycle path.

## Configuration
- `AES_KEYEXP_ZEROIZE_EN` defined: on the edge that completes the final transfer, the window, the captured key, the collect register and `out_key` are cleared to zero.
- `AES_KEYEXP_ZEROIZE_EN` undefined: these registers retain their last values. `out_key` continues to show round NR after `done`.

## Test plan
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, `out_ready`=1:
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `done` coincides with the round 10 valid after E44.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - round 12 = e98ba06f448c773c8ecc720401002202;
  - 13 transfers total.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - round 0 = first 128 key bits;
  - round 14 = fe4890d1e6188d0b046df344706c631e.
- Random `out_ready` stalls, NK=4:
  - the key sequence is identical to the unstalled run;
  - `out_key`/`out_round` are stable while `out_valid && !out_ready`;
  - no key is dropped or duplicated.
- `start` pulsed in RUN is ignored.
- `rst_n` low at round 5, then restart with a new key: all outputs are 0 during reset, and the new expansion begins at round 0 and is correct.
- `AES_KEYEXP_ZEROIZE_EN` defined: `out_key`=0 in the cycle after `done`. Undefined: it holds d014f9a8… (NK=4 vector).
